lcd_cmd_sequencer: RTL and testbench

//  Upstream feeder of the LCD enable-strobe stage on the C5G temperature display.

---
 rtl/lcd_cmd_sequencer.sv | 142 ++++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_sequencer.sv
// LCD command sequencer: runs the HD44780 8-bit power-up/init sequence, then
// forwards formatter bytes to the enable-strobe stage one transfer at a time.
module lcd_cmd_sequencer #(
  parameter int unsigned WAIT_PWRUP_CYC = 750000,
  parameter int unsigned WAIT_4100_CYC  = 205000,
  parameter int unsigned WAIT_1640_CYC  = 82000,
  parameter int unsigned WAIT_42_CYC    = 2100
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic        wr_rs,
  input  logic [7:0]  wr_data,
  output logic        lcd_req,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_data,
  output logic [22:0] wait_time,
  input  logic        lcd_done,
  output logic        init_done
);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT_ISSUE,
    S_INIT_WAIT,
    S_IDLE,
    S_WR_WAIT
  } state_t;

  localparam logic [22:0] PWRUP_LAST = 23'(WAIT_PWRUP_CYC - 1);
  localparam logic [22:0] W_4100     = 23'(WAIT_4100_CYC);
  localparam logic [22:0] W_1640     = 23'(WAIT_1640_CYC);
  localparam logic [22:0] W_42       = 23'(WAIT_42_CYC);
  localparam logic [2:0]  ROM_LAST   = 3'd5;

  state_t      state_q, state_d;
  logic [22:0] cnt_q, cnt_d;
  logic [2:0]  rom_idx_q, rom_idx_d;
  logic        req_d, rs_d, init_d;
  logic [7:0]  data_d;
  logic [22:0] wait_d;
  logic [7:0]  rom_data;
  logic [22:0] rom_wait;

  // Init ROM: command byte and post-command wait for each init step (RS=0)
  always_comb begin
    rom_data = 8'h38;
    rom_wait = W_42;
    case (rom_idx_q)
      3'd0:    begin rom_data = 8'h38; rom_wait = W_4100; end
      3'd1:    begin rom_data = 8'h38; rom_wait = W_4100; end
      3'd2:    begin rom_data = 8'h38; rom_wait = W_42;   end
      3'd3:    begin rom_data = 8'h0C; rom_wait = W_42;   end
      3'd4:    begin rom_data = 8'h01; rom_wait = W_1640; end
      3'd5:    begin rom_data = 8'h06; rom_wait = W_42;   end
      default: begin rom_data = 8'h38; rom_wait = W_42;   end
    endcase
  end

  // Next-state and next-output logic; transfer fields hold unless issued/accepted
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rom_idx_d = rom_idx_q;
    req_d     = lcd_req;
    rs_d      = lcd_rs;
    data_d    = lcd_data;
    wait_d    = wait_time;
    init_d    = init_done;
    case (state_q)
      S_PWRUP: begin
        cnt_d = cnt_q + 23'd1;
        if (cnt_q == PWRUP_LAST) state_d = S_INIT_ISSUE;
      end
      S_INIT_ISSUE: begin
        rs_d    = 1'b0;
        data_d  = rom_data;
        wait_d  = rom_wait;
        req_d   = 1'b1;
        state_d = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (lcd_done) begin
          req_d = 1'b0;
          if (rom_idx_q == ROM_LAST) begin
            init_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            rom_idx_d = rom_idx_q + 3'd1;
            state_d   = S_INIT_ISSUE;
          end
        end
      end
      S_IDLE: begin
        if (wr_valid) begin
          rs_d    = wr_rs;
          data_d  = wr_data;
          // clear (0x01) and return-home (0x02/0x03) are the slow commands
          wait_d  = (!wr_rs && (wr_data[7:2] == 6'd0)) ? W_1640 : W_42;
          req_d   = 1'b1;
          state_d = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        if (lcd_done) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_PWRUP;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_PWRUP;
      cnt_q     <= '0;
      rom_idx_q <= '0;
      lcd_req   <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= '0;
      wait_time <= '0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rom_idx_q <= rom_idx_d;
      lcd_req   <= req_d;
      lcd_rs    <= rs_d;
      lcd_data  <= data_d;
      wait_time <= wait_d;
      init_done <= init_d;
    end
  end

  assign wr_ready = (state_q == S_IDLE);
  assign lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Bench for lcd_cmd_sequencer: directed init/host/reset steps plus random host traffic.
module tb_lcd_cmd_sequencer;

  localparam int unsigned P_PWRUP = 20;
  localparam int unsigned P_4100  = 13;
  localparam int unsigned P_1640  = 9;
  localparam int unsigned P_42    = 5;
  localparam int BOUND = 200;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic        wr_rs = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        lcd_req;
  logic        lcd_rs;
  logic        lcd_rw;
  logic [7:0]  lcd_data;
  logic [22:0] wait_time;
  logic        lcd_done = 1'b0;
  logic        init_done;

  int tests_run = 0;
  int tests_failed = 0;

  lcd_cmd_sequencer #(
    .WAIT_PWRUP_CYC(P_PWRUP),
    .WAIT_4100_CYC (P_4100),
    .WAIT_1640_CYC (P_1640),
    .WAIT_42_CYC   (P_42)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_rs    (wr_rs),
    .wr_data  (wr_data),
    .lcd_req  (lcd_req),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_data (lcd_data),
    .wait_time(wait_time),
    .lcd_done (lcd_done),
    .init_done(init_done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait time a host byte must carry: slow for clear/home commands, fast otherwise
  function automatic logic [22:0] model_wait(input logic rs, input logic [7:0] d);
    if (rs == 1'b0 && d < 8'd4) return 23'(P_1640);
    return 23'(P_42);
  endfunction

  task automatic wait_req(input string tag, output int cyc);
    cyc = 0;
    while (lcd_req !== 1'b1 && cyc < BOUND) begin
      @(negedge CLK);
      cyc++;
    end
    chk({tag, " req"}, 64'(lcd_req), 64'd1);
  endtask

  // Called at the first negedge where lcd_req is high; answers it after 'delay' cycles
  task automatic serve(input string tag, input logic rs, input logic [7:0] d,
                       input logic [22:0] w, input int delay);
    int bad;
    chk({tag, " rs"}, 64'(lcd_rs), 64'(rs));
    chk({tag, " data"}, 64'(lcd_data), 64'(d));
    chk({tag, " wait"}, 64'(wait_time), 64'(w));
    chk({tag, " rw/ready"}, 64'({lcd_rw, wr_ready}), 64'd0);
    bad = 0;
    repeat (delay - 1) begin
      @(negedge CLK);
      if (lcd_req !== 1'b1 || lcd_rs !== rs || lcd_data !== d ||
          wait_time !== w || wr_ready !== 1'b0) bad++;
    end
    chk({tag, " hold"}, 64'(bad), 64'd0);
    lcd_done = 1'b1;
    @(negedge CLK);
    lcd_done = 1'b0;
    chk({tag, " drop"}, 64'(lcd_req), 64'd0);
    chk({tag, " keep"}, 64'({lcd_rs, lcd_data, wait_time}), 64'({rs, d, w}));
  endtask

  // Caller releases reset at a negedge immediately before calling
  task automatic do_init(input string tag);
    int cyc, bad;
    logic [7:0]  rd [6];
    logic [22:0] rw [6];
    rd = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    rw = '{23'(P_4100), 23'(P_4100), 23'(P_42), 23'(P_42), 23'(P_1640), 23'(P_42)};
    cyc = 0;
    bad = 0;
    wr_valid = 1'b1;
    wr_rs = 1'b1;
    wr_data = 8'($urandom);
    while (lcd_req !== 1'b1 && cyc < BOUND) begin
      @(negedge CLK);
      cyc++;
      if (wr_ready !== 1'b0 || init_done !== 1'b0) bad++;
      lcd_done = (cyc == 3);
    end
    lcd_done = 1'b0;
    wr_valid = 1'b0;
    chk({tag, " pwrup latency"}, 64'(cyc), 64'(P_PWRUP + 1));
    chk({tag, " pwrup ignores inputs"}, 64'(bad), 64'd0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        wait_req({tag, " init gap"}, cyc);
        chk({tag, " init issue gap"}, 64'(cyc), 64'd1);
      end
      serve($sformatf("%s init%0d", tag, i), 1'b0, rd[i], rw[i], 5);
      if (i < 5) chk({tag, " init_done low"}, 64'(init_done), 64'd0);
    end
    chk({tag, " init_done/ready"}, 64'({init_done, wr_ready}), 64'b11);
  endtask

  task automatic host_xfer(input string tag, input logic rs, input logic [7:0] d,
                           input int gap, input int delay);
    repeat (gap) @(negedge CLK);
    chk({tag, " ready before"}, 64'(wr_ready), 64'd1);
    wr_valid = 1'b1;
    wr_rs = rs;
    wr_data = d;
    @(negedge CLK);
    wr_valid = 1'b0;
    chk({tag, " req next cycle"}, 64'(lcd_req), 64'd1);
    serve(tag, rs, d, model_wait(rs, d), delay);
    chk({tag, " ready after"}, 64'(wr_ready), 64'd1);
  endtask

  initial begin
    int cyc, bad;
    logic        rrs;
    logic [7:0]  rd;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("reset outputs", 64'({wr_ready, lcd_req, lcd_rs, lcd_rw, lcd_data, wait_time, init_done}), 64'd0);
    RST_N = 1'b1;
    do_init("init1");

    // Character 'A'
    host_xfer("char41", 1'b1, 8'h41, 0, 3);

    // Held wr_valid across two commands
    wr_valid = 1'b1;
    wr_rs = 1'b0;
    wr_data = 8'h01;
    @(negedge CLK);
    chk("hold1 req", 64'(lcd_req), 64'd1);
    wr_data = 8'h80;
    serve("hold cmd01", 1'b0, 8'h01, 23'(P_1640), 4);
    chk("hold ready between", 64'(wr_ready), 64'd1);
    @(negedge CLK);
    wr_valid = 1'b0;
    chk("hold2 req", 64'(lcd_req), 64'd1);
    serve("hold cmd80", 1'b0, 8'h80, 23'(P_42), 2);
    bad = 0;
    repeat (5) begin
      @(negedge CLK);
      if (lcd_req !== 1'b0 || wr_ready !== 1'b1) bad++;
    end
    chk("hold no third", 64'(bad), 64'd0);

    // Stray lcd_done in idle
    lcd_done = 1'b1;
    @(negedge CLK);
    lcd_done = 1'b0;
    @(negedge CLK);
    chk("idle done ignored", 64'({lcd_req, wr_ready, init_done, lcd_data}), 64'({3'b011, 8'h80}));

    // Random host traffic, biased toward the clear/home boundary
    for (int n = 0; n < 40; n++) begin
      rrs = 1'($urandom);
      if ($urandom_range(3) == 0) rd = 8'($urandom_range(5));
      else rd = 8'($urandom);
      host_xfer($sformatf("rnd%0d", n), rrs, rd, int'($urandom_range(2)), 1 + int'($urandom_range(5)));
    end

    // Reset while a host transfer is outstanding
    wr_valid = 1'b1;
    wr_rs = 1'b0;
    wr_data = 8'h55;
    @(negedge CLK);
    wr_valid = 1'b0;
    wait_req("rst xfer", cyc);
    @(negedge CLK);
    chk("rst pre req", 64'(lcd_req), 64'd1);
    RST_N = 1'b0;
    #1;
    chk("rst async drop", 64'({lcd_req, init_done, wr_ready, lcd_data}), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    do_init("init2");
    host_xfer("post rst", 1'b0, 8'h02, 1, 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
